step_pulse_gen: RTL and testbench
=================================

# step_pulse_gen

Clock-source front end for the manual/auto stepping path. It produces the two step signals that the downstream clock-select stage chooses between using `AUTO`:
- a debounced single-cycle pulse per pushbutton press;
- a programmable-rate auto tick.

Both outputs are one-`CLK`-cycle-wide enables, synchronous to the system clock, so the downstream selector switches between clean, glitch-free sources.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable synchronized samples required to accept a button level change. Minimum 1.
- `AUTO_DIV`, default 50000000: auto tick period in `CLK` cycles. Minimum 1.
- `REPEAT_CYCLES`, default 25000000: hold-to-repeat period. Used only with `STEP_AUTO_REPEAT_EN`.
- `CLK` (in, 1): system clock. Everything in the block is clocked on its rising edge.
- `RST_n` (in, 1): reset. Synchronous and active-low.
- `BTN_raw` (in, 1): asynchronous, bouncy pushbutton, active-high.
- `AUTO` (in, 1): auto-run enable, synchronous to `CLK`.
- `CLK_pushbutton` (out, 1): one-cycle pulse per accepted press.
- `CLK_auto` (out, 1): one-cycle tick every `AUTO_DIV` cycles while `AUTO`=1.
- `BTN_level` (out, 1): debounced button level.

## Operation
- **Synchronizer.** `BTN_raw` passes through a 2-FF synchronizer. The second flop's output is `btn_s`.
- **Debounce FSM.** Uses a counter `db_cnt` of width `$clog2(DEBOUNCE_CYCLES+1)`.
  - `RELEASED`: `BTN_level`=0. If `btn_s`=1, go to `PRESS_WAIT` with `db_cnt`=1.
  - `PRESS_WAIT`:
    - If `btn_s`=0, return to `RELEASED` and clear `db_cnt`.
    - Else if `db_cnt`=`DEBOUNCE_CYCLES`, go to `PRESSED` and emit the pulse.
    - Else increment `db_cnt`.
  - `PRESSED`: `BTN_level`=1. If `btn_s`=0, go to `RELEASE_WAIT` with `db_cnt`=1.
  - `RELEASE_WAIT`: mirror of `PRESS_WAIT`.
    - If `btn_s`=1, return to `PRESSED`.
    - Else if `db_cnt`=`DEBOUNCE_CYCLES`, go to `RELEASED`.
    - Else increment `db_cnt`.
  - Any bounce restarts qualification. No pulse is emitted on release.
- **Auto divider.** Uses a counter `au_cnt` of width `$clog2(AUTO_DIV)` (minimum 1 bit).
  - While `AUTO`=1: counts 0..`AUTO_DIV`-1. `CLK_auto`=1 in the cycle after `au_cnt`=`AUTO_DIV`-1, and `au_cnt` wraps to 0.
  - `AUTO`=0: `au_cnt` is cleared to 0 and `CLK_auto` is forced to 0 in the next cycle.
  - With `AUTO_DIV`=1, `CLK_auto` is 1 every cycle while `AUTO` is held, after 1 cycle of latency.
- **Independence.** Pushbutton and auto paths run regardless of `AUTO`. Selection happens downstream.
- **Registered outputs.** All outputs are registered. There is no combinational path from any input to any output.

## Timing
- **Reset.** When `RST_n`=0 at a `CLK` edge:
  - FSM goes to `RELEASED`.
  - `db_cnt`, `au_cnt` and both synchronizer flops are cleared to 0.
  - `CLK_pushbutton`, `CLK_auto` and `BTN_level` are 0.
  - Reset mid-qualification or mid-hold discards progress. No pulse is emitted on reset release, even if the button is still held; a new press qualification starts from `RELEASED`.
- **Press latency.** `BTN_raw` rises and stays high. `CLK_pushbutton` is high for exactly 1 cycle, `DEBOUNCE_CYCLES`+3 cycles after the first edge that samples `BTN_raw`=1:
  - 2 cycles of synchronization;
  - `DEBOUNCE_CYCLES` cycles of qualification;
  - 1 output register.
  - `BTN_level` rises in the same cycle as the pulse.
- **Release latency.** `BTN_level` falls `DEBOUNCE_CYCLES`+3 cycles after `BTN_raw` falls.
- **Auto latency.** The first `CLK_auto` occurs `AUTO_DIV` cycles after the first edge that samples `AUTO`=1. Subsequent ticks have a period of exactly `AUTO_DIV`. Ticks never merge, except in the `AUTO_DIV`=1 case.
- **Simultaneous events.** A press pulse and an auto tick in the same cycle are both asserted.

## Configuration
- **Macro:** `STEP_AUTO_REPEAT_EN`.
- **Defined:**
  - While in `PRESSED`, a counter `rp_cnt` runs.
  - Every `REPEAT_CYCLES` cycles of continuous hold, an extra one-cycle `CLK_pushbutton` pulse is emitted.
  - Entering `RELEASE_WAIT` or reset clears `rp_cnt`.
  - A bounce back to `PRESSED` from `RELEASE_WAIT` also restarts `rp_cnt` from 0.
- **Undefined:**
  - Exactly one pulse per accepted press.
  - `REPEAT_CYCLES` is ignored and no `rp_cnt` logic is synthesized.

## Structure
- **Package `step_pkg`:**
  - `typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} db_state_t`;
  - a width helper function: `clog2` of the argument, with a minimum of 1.
- **Sub-module `sync_2ff`:** a 1-bit two-flop synchronizer with reset value 0. It is instantiated once for `BTN_raw`.
- Everything else lives in `step_pulse_gen`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `AUTO_DIV`=5 and `REPEAT_CYCLES`=8.
- **Clean press.** `BTN_raw` 0→1 held 20 cycles → exactly one `CLK_pushbutton` pulse at cycle 7 after the sampling edge. `BTN_level`=1 from cycle 7.
- **Bounce.** `BTN_raw` toggles 1,0,1,0 on successive cycles, then holds at 1 → no pulse during the bounce. Exactly one pulse 7 cycles after the final rising edge.
- **Auto tick.** `AUTO`=1 for 22 cycles → `CLK_auto` pulses at cycles 5, 10, 15 and 20. Drop `AUTO` → `CLK_auto`=0 from the next cycle. Re-raise `AUTO` → first tick after 5 cycles again.
- **Reset mid-qualification.** `BTN_raw`=1, then `RST_n`=0 for 1 cycle at cycle 4, then `BTN_raw` held → all outputs 0 during reset. A single pulse 7 cycles after the first sampling edge following reset release.
- **Simultaneous events.** Time the press so its pulse coincides with an auto tick → both outputs high in the same cycle.
- **Repeat (`STEP_AUTO_REPEAT_EN` defined).** Hold 30 cycles → pulses at cycle 7, 15, 23 and 31. Without the macro → only the pulse at cycle 7.

Source files
------------

// File: rtl/step_pkg.sv
// Shared types and helpers for the manual/auto stepping clock-source front end.
package step_pkg;

   typedef enum logic [1:0] {
      RELEASED,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } db_state_t;

   // Counter width for a value range, never narrower than one bit.
   function automatic int clog2_min1(input int value);
      int w;
      w = $clog2(value);
      if (w < 1) w = 1;
      return w;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// One-bit two-flop synchronizer for bringing an asynchronous level into the clk domain.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/step_pulse_gen.sv
// Debounced pushbutton step pulse plus programmable-rate auto tick, both one-cycle enables.
// Optional hold-to-repeat pulses are built when STEP_AUTO_REPEAT_EN is defined.
module step_pulse_gen
   import step_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int AUTO_DIV        = 50000000,
   parameter int REPEAT_CYCLES   = 25000000
) (
   input  logic CLK,
   input  logic RST_n,
   input  logic BTN_raw,
   input  logic AUTO,
   output logic CLK_pushbutton,
   output logic CLK_auto,
   output logic BTN_level
);

   localparam int DB_W = clog2_min1(DEBOUNCE_CYCLES + 1);
   localparam int AU_W = clog2_min1(AUTO_DIV);
   localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES);
   localparam logic [AU_W-1:0] AU_MAX = AU_W'(AUTO_DIV - 1);

   if (DEBOUNCE_CYCLES < 1 || AUTO_DIV < 1 || REPEAT_CYCLES < 1) begin : g_param_check
      $error("step_pulse_gen: DEBOUNCE_CYCLES, AUTO_DIV and REPEAT_CYCLES must be >= 1");
   end

   logic            btn_s;
   db_state_t       state;
   db_state_t       state_next;
   logic [DB_W-1:0] db_cnt;
   logic [DB_W-1:0] db_cnt_next;
   logic            press_accept;
   logic            level_next;
   logic [AU_W-1:0] au_cnt;
   logic [AU_W-1:0] au_cnt_next;
   logic            tick_next;
   logic            repeat_fire;

   sync_2ff u_btn_sync (
      .clk   (CLK),
      .rst_n (RST_n),
      .d     (BTN_raw),
      .q     (btn_s)
   );

   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         state  <= RELEASED;
         db_cnt <= '0;
      end else begin
         state  <= state_next;
         db_cnt <= db_cnt_next;
      end
   end

   // Any sample that disagrees with the candidate level restarts qualification.
   always_comb begin
      state_next   = state;
      db_cnt_next  = db_cnt;
      press_accept = 1'b0;
      case (state)
         RELEASED: begin
            if (btn_s) begin
               state_next  = PRESS_WAIT;
               db_cnt_next = DB_W'(1);
            end
         end
         PRESS_WAIT: begin
            if (!btn_s) begin
               state_next  = RELEASED;
               db_cnt_next = '0;
            end else if (db_cnt == DB_MAX) begin
               state_next   = PRESSED;
               db_cnt_next  = '0;
               press_accept = 1'b1;
            end else begin
               db_cnt_next = db_cnt + 1'b1;
            end
         end
         PRESSED: begin
            if (!btn_s) begin
               state_next  = RELEASE_WAIT;
               db_cnt_next = DB_W'(1);
            end
         end
         RELEASE_WAIT: begin
            if (btn_s) begin
               state_next  = PRESSED;
               db_cnt_next = '0;
            end else if (db_cnt == DB_MAX) begin
               state_next  = RELEASED;
               db_cnt_next = '0;
            end else begin
               db_cnt_next = db_cnt + 1'b1;
            end
         end
         default: begin
            state_next  = RELEASED;
            db_cnt_next = '0;
         end
      endcase
      level_next = (state_next == PRESSED) || (state_next == RELEASE_WAIT);
   end

   // Tick is decided on the terminal count so it appears exactly AUTO_DIV cycles after AUTO rises.
   always_comb begin
      au_cnt_next = '0;
      tick_next   = 1'b0;
      if (AUTO) begin
         if (au_cnt == AU_MAX) begin
            tick_next = 1'b1;
         end else begin
            au_cnt_next = au_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         au_cnt <= '0;
      end else begin
         au_cnt <= au_cnt_next;
      end
   end

`ifdef STEP_AUTO_REPEAT_EN
   localparam int RP_W = clog2_min1(REPEAT_CYCLES);
   localparam logic [RP_W-1:0] RP_MAX = RP_W'(REPEAT_CYCLES - 1);

   logic [RP_W-1:0] rp_cnt;
   logic            holding;

   assign holding     = (state == PRESSED) && btn_s;
   assign repeat_fire = holding && (rp_cnt == RP_MAX);

   // Only uninterrupted time in PRESSED counts toward the next repeat.
   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         rp_cnt <= '0;
      end else if (holding && !repeat_fire) begin
         rp_cnt <= rp_cnt + 1'b1;
      end else begin
         rp_cnt <= '0;
      end
   end
`else
   assign repeat_fire = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         CLK_pushbutton <= 1'b0;
         CLK_auto       <= 1'b0;
         BTN_level      <= 1'b0;
      end else begin
         CLK_pushbutton <= press_accept | repeat_fire;
         CLK_auto       <= tick_next;
         BTN_level      <= level_next;
      end
   end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Scoreboard bench for step_pulse_gen: expected pulse cycles are queued as stimulus is driven.
module tb_step_pulse_gen;

   localparam int DB = 4;
   localparam int AD = 5;
   localparam int RP = 8;

   logic CLK;
   logic RST_n;
   logic BTN_raw;
   logic AUTO;
   logic CLK_pushbutton;
   logic CLK_auto;
   logic BTN_level;

   int n_cmp;
   int n_bad;
   int q_push[$];
   int q_auto[$];

   step_pulse_gen #(
      .DEBOUNCE_CYCLES (DB),
      .AUTO_DIV        (AD),
      .REPEAT_CYCLES   (RP)
   ) dut (
      .CLK            (CLK),
      .RST_n          (RST_n),
      .BTN_raw        (BTN_raw),
      .AUTO           (AUTO),
      .CLK_pushbutton (CLK_pushbutton),
      .CLK_auto       (CLK_auto),
      .BTN_level      (BTN_level)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Inputs change and outputs are observed on the falling edge.
   task automatic tick();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   // Queue the press pulse plus any repeats the hold is long enough to produce.
   task automatic push_press(input int press_k, input int rel_k);
      q_push.push_back(press_k + DB + 3);
`ifdef STEP_AUTO_REPEAT_EN
      for (int c = press_k + DB + 3 + RP; c <= rel_k + 2; c += RP) q_push.push_back(c);
`endif
   endtask

   task automatic test_reset();
      RST_n = 1'b0; BTN_raw = 1'b1; AUTO = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_cmp += 3;
         if (CLK_pushbutton !== 1'b0) begin n_bad++; $display("[TB] FAIL reset.push: got %b, expected 0", CLK_pushbutton); end
         if (CLK_auto !== 1'b0) begin n_bad++; $display("[TB] FAIL reset.auto: got %b, expected 0", CLK_auto); end
         if (BTN_level !== 1'b0) begin n_bad++; $display("[TB] FAIL reset.level: got %b, expected 0", BTN_level); end
      end
      RST_n = 1'b1; BTN_raw = 1'b0; AUTO = 1'b0;
      for (int k = 0; k < 4; k++) tick();
   endtask

   task automatic test_clean_press();
      int n, exp_c, first, fall;
      logic lv_exp;
      first = DB + 3;
      fall  = 20 + DB + 3;
      for (int k = 0; k < 34; k++) begin
         if (k == 0) push_press(0, 20);
         BTN_raw = (k < 20);
         tick();
         n = k + 1;
         if (CLK_pushbutton === 1'b1) begin
            n_cmp++;
            if (q_push.size() == 0) begin n_bad++; $display("[TB] FAIL clean.push: pulse at cycle %0d, none expected", n); end
            else begin
               exp_c = q_push.pop_front();
               if (n !== exp_c) begin n_bad++; $display("[TB] FAIL clean.push: pulse at cycle %0d, expected cycle %0d", n, exp_c); end
            end
         end
         if (CLK_auto === 1'b1) begin
            n_cmp++; n_bad++;
            $display("[TB] FAIL clean.auto: tick at cycle %0d, none expected", n);
         end
         lv_exp = (n >= first) && (n < fall);
         n_cmp++;
         if (BTN_level !== lv_exp) begin n_bad++; $display("[TB] FAIL clean.level: cycle %0d got %b, expected %b", n, BTN_level, lv_exp); end
      end
      n_cmp++;
      if (q_push.size() != 0) begin n_bad++; $display("[TB] FAIL clean.missing: %0d pulses not seen, expected 0 left", q_push.size()); q_push.delete(); end
   endtask

   task automatic test_bounce();
      int n, exp_c, first, fall;
      logic lv_exp;
      first = 4 + DB + 3;
      fall  = 20 + DB + 3;
      for (int k = 0; k < 34; k++) begin
         if (k == 4) push_press(4, 20);
         BTN_raw = (k == 0) || (k == 2) || (k >= 4 && k < 20);
         tick();
         n = k + 1;
         if (CLK_pushbutton === 1'b1) begin
            n_cmp++;
            if (q_push.size() == 0) begin n_bad++; $display("[TB] FAIL bounce.push: pulse at cycle %0d, none expected", n); end
            else begin
               exp_c = q_push.pop_front();
               if (n !== exp_c) begin n_bad++; $display("[TB] FAIL bounce.push: pulse at cycle %0d, expected cycle %0d", n, exp_c); end
            end
         end
         if (CLK_auto === 1'b1) begin
            n_cmp++; n_bad++;
            $display("[TB] FAIL bounce.auto: tick at cycle %0d, none expected", n);
         end
         lv_exp = (n >= first) && (n < fall);
         n_cmp++;
         if (BTN_level !== lv_exp) begin n_bad++; $display("[TB] FAIL bounce.level: cycle %0d got %b, expected %b", n, BTN_level, lv_exp); end
      end
      n_cmp++;
      if (q_push.size() != 0) begin n_bad++; $display("[TB] FAIL bounce.missing: %0d pulses not seen, expected 0 left", q_push.size()); q_push.delete(); end
   endtask

   task automatic test_auto_tick();
      int n, exp_c;
      for (int k = 0; k < 36; k++) begin
         if (k == 0) for (int c = AD; c <= 22; c += AD) q_auto.push_back(c);
         if (k == 26) q_auto.push_back(26 + AD);
         AUTO = (k < 22) || (k >= 26 && k < 32);
         tick();
         n = k + 1;
         if (CLK_auto === 1'b1) begin
            n_cmp++;
            if (q_auto.size() == 0) begin n_bad++; $display("[TB] FAIL auto.tick: tick at cycle %0d, none expected", n); end
            else begin
               exp_c = q_auto.pop_front();
               if (n !== exp_c) begin n_bad++; $display("[TB] FAIL auto.tick: tick at cycle %0d, expected cycle %0d", n, exp_c); end
            end
         end
         if (n == 23) begin
            n_cmp++;
            if (CLK_auto !== 1'b0) begin n_bad++; $display("[TB] FAIL auto.drop: got %b after AUTO fell, expected 0", CLK_auto); end
         end
         n_cmp++;
         if (CLK_pushbutton !== 1'b0 || BTN_level !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL auto.idle: cycle %0d push=%b level=%b, expected 0/0", n, CLK_pushbutton, BTN_level);
         end
      end
      n_cmp++;
      if (q_auto.size() != 0) begin n_bad++; $display("[TB] FAIL auto.missing: %0d ticks not seen, expected 0 left", q_auto.size()); q_auto.delete(); end
   endtask

   task automatic test_reset_mid();
      int n, exp_c, first, fall;
      logic lv_exp;
      first = 5 + DB + 3;
      fall  = 20 + DB + 3;
      for (int k = 0; k < 34; k++) begin
         if (k == 5) push_press(5, 20);
         BTN_raw = (k < 20);
         RST_n   = (k != 4);
         tick();
         n = k + 1;
         if (n == 5) begin
            n_cmp++;
            if ({CLK_pushbutton, CLK_auto, BTN_level} !== 3'b000) begin
               n_bad++;
               $display("[TB] FAIL rstmid.outs: got %b%b%b in reset, expected 000", CLK_pushbutton, CLK_auto, BTN_level);
            end
         end
         if (CLK_pushbutton === 1'b1) begin
            n_cmp++;
            if (q_push.size() == 0) begin n_bad++; $display("[TB] FAIL rstmid.push: pulse at cycle %0d, none expected", n); end
            else begin
               exp_c = q_push.pop_front();
               if (n !== exp_c) begin n_bad++; $display("[TB] FAIL rstmid.push: pulse at cycle %0d, expected cycle %0d", n, exp_c); end
            end
         end
         lv_exp = (n >= first) && (n < fall);
         n_cmp++;
         if (BTN_level !== lv_exp) begin n_bad++; $display("[TB] FAIL rstmid.level: cycle %0d got %b, expected %b", n, BTN_level, lv_exp); end
      end
      RST_n = 1'b1;
      n_cmp++;
      if (q_push.size() != 0) begin n_bad++; $display("[TB] FAIL rstmid.missing: %0d pulses not seen, expected 0 left", q_push.size()); q_push.delete(); end
   endtask

   task automatic test_simultaneous();
      int n, exp_c, first, fall;
      logic lv_exp;
      first = 3 + DB + 3;
      fall  = 20 + DB + 3;
      for (int k = 0; k < 34; k++) begin
         if (k == 0) for (int c = AD; c <= 20; c += AD) q_auto.push_back(c);
         if (k == 3) push_press(3, 20);
         AUTO    = (k < 20);
         BTN_raw = (k >= 3) && (k < 20);
         tick();
         n = k + 1;
         if (n == first) begin
            n_cmp++;
            if (CLK_pushbutton !== 1'b1 || CLK_auto !== 1'b1) begin
               n_bad++;
               $display("[TB] FAIL simul.both: push=%b auto=%b at cycle %0d, expected 1/1", CLK_pushbutton, CLK_auto, n);
            end
         end
         if (CLK_pushbutton === 1'b1) begin
            n_cmp++;
            if (q_push.size() == 0) begin n_bad++; $display("[TB] FAIL simul.push: pulse at cycle %0d, none expected", n); end
            else begin
               exp_c = q_push.pop_front();
               if (n !== exp_c) begin n_bad++; $display("[TB] FAIL simul.push: pulse at cycle %0d, expected cycle %0d", n, exp_c); end
            end
         end
         if (CLK_auto === 1'b1) begin
            n_cmp++;
            if (q_auto.size() == 0) begin n_bad++; $display("[TB] FAIL simul.auto: tick at cycle %0d, none expected", n); end
            else begin
               exp_c = q_auto.pop_front();
               if (n !== exp_c) begin n_bad++; $display("[TB] FAIL simul.auto: tick at cycle %0d, expected cycle %0d", n, exp_c); end
            end
         end
         lv_exp = (n >= first) && (n < fall);
         n_cmp++;
         if (BTN_level !== lv_exp) begin n_bad++; $display("[TB] FAIL simul.level: cycle %0d got %b, expected %b", n, BTN_level, lv_exp); end
      end
      n_cmp++;
      if (q_push.size() != 0 || q_auto.size() != 0) begin
         n_bad++;
         $display("[TB] FAIL simul.missing: %0d pulses and %0d ticks not seen, expected 0 left", q_push.size(), q_auto.size());
         q_push.delete(); q_auto.delete();
      end
   endtask

   task automatic test_repeat();
      int n, exp_c, first, fall;
      logic lv_exp;
      first = DB + 3;
      fall  = 30 + DB + 3;
      for (int k = 0; k < 44; k++) begin
         if (k == 0) push_press(0, 30);
         BTN_raw = (k < 30);
         tick();
         n = k + 1;
         if (CLK_pushbutton === 1'b1) begin
            n_cmp++;
            if (q_push.size() == 0) begin n_bad++; $display("[TB] FAIL repeat.push: pulse at cycle %0d, none expected", n); end
            else begin
               exp_c = q_push.pop_front();
               if (n !== exp_c) begin n_bad++; $display("[TB] FAIL repeat.push: pulse at cycle %0d, expected cycle %0d", n, exp_c); end
            end
         end
         if (CLK_auto === 1'b1) begin
            n_cmp++; n_bad++;
            $display("[TB] FAIL repeat.auto: tick at cycle %0d, none expected", n);
         end
         lv_exp = (n >= first) && (n < fall);
         n_cmp++;
         if (BTN_level !== lv_exp) begin n_bad++; $display("[TB] FAIL repeat.level: cycle %0d got %b, expected %b", n, BTN_level, lv_exp); end
      end
      n_cmp++;
      if (q_push.size() != 0) begin n_bad++; $display("[TB] FAIL repeat.missing: %0d pulses not seen, expected 0 left", q_push.size()); q_push.delete(); end
   endtask

   initial begin
      n_cmp   = 0;
      n_bad   = 0;
      RST_n   = 1'b0;
      BTN_raw = 1'b0;
      AUTO    = 1'b0;
      @(negedge CLK);
      $display("[TB] starting step_pulse_gen scenarios");
      test_reset();
      test_clean_press();
      test_bounce();
      test_auto_tick();
      test_reset_mid();
      test_simultaneous();
      test_repeat();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
